// File: rtl/demux_arb_pkg.sv
// Shared definitions for the demux arbiter: FSM encoding, default widths and
// the destination one-hot decoder.
package demux_arb_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned SEL_W_DEF  = 3;
    localparam int unsigned NUM_DEST   = 1 << SEL_W_DEF;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    // One-hot decode of a destination index into a write-strobe vector
    function automatic logic [NUM_DEST-1:0] dest_onehot(input logic [SEL_W_DEF-1:0] sel);
        dest_onehot = NUM_DEST'(1) << sel;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotate-priority arbiter: the search starts one past ptr and
// wraps modulo N; the caller owns and updates the pointer register.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned PTR_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic [PTR_W:0]   w_sum;
    logic [PTR_W-1:0] w_idx;
    logic             w_found;

    // First asserted request after ptr, wrapping around
    always_comb begin
        gnt     = '0;
        w_sum   = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int i = 1; i <= int'(N); i++) begin
            w_sum = {1'b0, ptr} + (PTR_W+1)'(i);
            if (w_sum >= (PTR_W+1)'(N)) begin
                w_sum = w_sum - (PTR_W+1)'(N);
            end
            w_idx = w_sum[PTR_W-1:0];
            if (!w_found && req[w_idx]) begin
                gnt[w_idx] = 1'b1;
                w_found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/demux_arbiter.sv
// Round-robin arbiter sharing one 8-way output demux among NUM_REQ producers.
// A granted request is captured, then driven onto the demux from registers
// until the addressed destination is ready, at which point a single one-hot
// write strobe is issued.
// Optional: DEMUX_ARB_WAIT_TIMEOUT_EN abandons a transfer (drop_err pulse)
// after TIMEOUT+1 ISSUE cycles without destination ready.
module demux_arbiter
    import demux_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned SEL_W   = SEL_W_DEF,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    input  logic [NUM_REQ*SEL_W-1:0]    req_dest,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [(2**SEL_W)-1:0]       dest_ready,
    output logic [DATA_W-1:0]           dmx_data,
    output logic [SEL_W-1:0]            dmx_select,
    output logic [(2**SEL_W)-1:0]       dmx_we,
    output logic                        busy,
    output logic                        drop_err
);

    localparam int unsigned N_DEST = 2**SEL_W;
    localparam int unsigned PTR_W  = $clog2(NUM_REQ);

    // Reject out-of-range configurations at elaboration
    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT == 0) begin : g_bad_cfg
        $error("demux_arbiter: NUM_REQ must be 2..8 and TIMEOUT nonzero");
    end

    state_t             r_state;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [DATA_W-1:0]  r_data_q;
    logic [SEL_W-1:0]   r_dest_q;
    logic               r_busy;

    logic [NUM_REQ-1:0] w_gnt;
    logic [PTR_W-1:0]   w_gnt_idx;
    logic [DATA_W-1:0]  w_sel_data;
    logic [SEL_W-1:0]   w_sel_dest;
    logic [N_DEST-1:0]  w_dest_oh;
    logic               w_dest_rdy;
    logic               w_drop;

    rr_arbiter #(
        .N     (NUM_REQ),
        .PTR_W (PTR_W)
    ) u_rr_arbiter (
        .req (req_valid),
        .ptr (r_rr_ptr),
        .gnt (w_gnt)
    );

    // Encode the grant and mux the winning requester's payload
    always_comb begin
        w_gnt_idx  = '0;
        w_sel_data = '0;
        w_sel_dest = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (w_gnt[i]) begin
                w_gnt_idx  = PTR_W'(i);
                w_sel_data = req_data[i*DATA_W +: DATA_W];
                w_sel_dest = req_dest[i*SEL_W +: SEL_W];
            end
        end
    end

    if (SEL_W == SEL_W_DEF) begin : g_dec_pkg
        assign w_dest_oh = dest_onehot(r_dest_q);
    end else begin : g_dec_gen
        assign w_dest_oh = N_DEST'(1) << r_dest_q;
    end

    assign w_dest_rdy = dest_ready[r_dest_q];
    assign req_ready  = (r_state == IDLE) ? w_gnt : '0;
    assign dmx_we     = (r_state == ISSUE && w_dest_rdy) ? w_dest_oh : '0;
    assign dmx_data   = r_data_q;
    assign dmx_select = r_dest_q;
    assign busy       = r_busy;

`ifdef DEMUX_ARB_WAIT_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] r_wait_cnt;

    // Give up on a destination that stays not-ready through the final wait cycle
    assign w_drop   = (r_state == ISSUE) && !w_dest_rdy && (r_wait_cnt == CNT_W'(TIMEOUT));
    assign drop_err = w_drop;
`else
    assign w_drop   = 1'b0;
    assign drop_err = 1'b0;
`endif

    // Arbitration / issue FSM with capture registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rr_ptr   <= PTR_W'(NUM_REQ - 1);
            r_data_q   <= '0;
            r_dest_q   <= '0;
            r_busy     <= 1'b0;
`ifdef DEMUX_ARB_WAIT_TIMEOUT_EN
            r_wait_cnt <= '0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req_valid) begin
                        r_data_q   <= w_sel_data;
                        r_dest_q   <= w_sel_dest;
                        r_rr_ptr   <= w_gnt_idx;
                        r_state    <= ISSUE;
                        r_busy     <= 1'b1;
`ifdef DEMUX_ARB_WAIT_TIMEOUT_EN
                        r_wait_cnt <= '0;
`endif
                    end
                end
                ISSUE: begin
                    if (w_dest_rdy || w_drop) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
`ifdef DEMUX_ARB_WAIT_TIMEOUT_EN
                    else begin
                        r_wait_cnt <= r_wait_cnt + CNT_W'(1);
                    end
`endif
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_demux_arbiter.sv
// Bench for demux_arbiter: a cycle reference model predicts grants, strobes
// and status; accepted transfers go into a scoreboard queue that a separate
// monitor drains whenever the DUT strobes a destination.
module tb_demux_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int SW = 3;
    localparam int ND = 8;
    localparam int TO = 15;
`ifdef DEMUX_ARB_WAIT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [NR-1:0]     req_valid;
    logic [NR*DW-1:0]  req_data;
    logic [NR*SW-1:0]  req_dest;
    logic [NR-1:0]     req_ready;
    logic [ND-1:0]     dest_ready;
    logic [DW-1:0]     dmx_data;
    logic [SW-1:0]     dmx_select;
    logic [ND-1:0]     dmx_we;
    logic              busy;
    logic              drop_err;

    int total = 0;
    int bad   = 0;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [SW-1:0] dest;
    } xfer_t;

    xfer_t exp_q[$];

    // Reference model state
    bit            m_busy;
    int            m_ptr;
    logic [DW-1:0] m_data;
    logic [SW-1:0] m_dest;
    int            m_cnt;

    demux_arbiter #(
        .NUM_REQ (NR),
        .DATA_W  (DW),
        .SEL_W   (SW),
        .TIMEOUT (TO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_dest   (req_dest),
        .req_ready  (req_ready),
        .dest_ready (dest_ready),
        .dmx_data   (dmx_data),
        .dmx_select (dmx_select),
        .dmx_we     (dmx_we),
        .busy       (busy),
        .drop_err   (drop_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, expv);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_ptr  = NR - 1;
        m_data = '0;
        m_dest = '0;
        m_cnt  = 0;
        exp_q.delete();
    endtask

    // Round-robin pick: first valid requester after the last grant
    function automatic int pick(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++) begin
            int idx;
            idx = (last + k) % NR;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // One clock: predict, check at negedge, advance model, return at posedge+1
    task automatic step(output int granted);
        int            g;
        logic [NR-1:0] e_ready;
        logic [ND-1:0] e_we;
        logic          e_drop;
        logic          rdy;
        granted = -1;
        g       = -1;
        e_ready = '0;
        e_we    = '0;
        e_drop  = 1'b0;
        rdy     = 1'b0;
        if (!m_busy) begin
            g = pick(req_valid, m_ptr);
            if (g >= 0) e_ready = NR'(1) << g;
        end else begin
            rdy = dest_ready[m_dest];
            if (rdy) e_we = ND'(1) << m_dest;
            else if (TO_EN && m_cnt == TO) e_drop = 1'b1;
        end
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(e_ready));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("drop_err", 32'(drop_err), 32'(e_drop));
        chk("dmx_we", 32'(dmx_we), 32'(e_we));
        chk("dmx_data", 32'(dmx_data), 32'(m_data));
        chk("dmx_select", 32'(dmx_select), 32'(m_dest));
        if (!m_busy) begin
            if (g >= 0) begin
                m_data = req_data[g*DW +: DW];
                m_dest = req_dest[g*SW +: SW];
                exp_q.push_back({m_data, m_dest});
                m_busy  = 1'b1;
                m_ptr   = g;
                m_cnt   = 0;
                granted = g;
            end
        end else if (rdy || e_drop) begin
            m_busy = 1'b0;
            if (e_drop) begin
                xfer_t dummy;
                dummy = exp_q.pop_back();
            end
        end else begin
            m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Scoreboard monitor: every strobe must match the oldest accepted transfer
    initial begin
        xfer_t e;
        forever begin
            @(negedge clk);
            if (!reset && dmx_we != '0) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_write: got we=%0h want none", dmx_we);
                end else begin
                    e = exp_q.pop_front();
                    chk("mon_we", 32'(dmx_we), 32'(ND'(1) << e.dest));
                    chk("mon_data", 32'(dmx_data), 32'(e.data));
                    chk("mon_sel", 32'(dmx_select), 32'(e.dest));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int gr;
        int seen[$];
        int bcnt;
        req_valid  = '0;
        req_data   = '0;
        req_dest   = '0;
        dest_ready = '1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_we", 32'(dmx_we), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_drop", 32'(drop_err), 0);
        chk("rst_data", 32'(dmx_data), 0);
        chk("rst_sel", 32'(dmx_select), 0);

        // First grant straight out of reset
        req_valid      = 4'b0001;
        req_data[7:0]  = 8'hA5;
        req_dest[2:0]  = 3'd5;
        reset          = 1'b0;
        #1;
        chk("t1_ready", 32'(req_ready), 32'h1);
        step(gr);
        req_valid = '0;
        chk("t1_sel", 32'(dmx_select), 5);
        chk("t1_data", 32'(dmx_data), 32'hA5);
        chk("t1_we", 32'(dmx_we), 32'h20);
        step(gr);
        chk("t1_idle", 32'(busy), 0);

        // All requesters held valid: rotation 0,1,2,3,0
        do_reset();
        for (int i = 0; i < NR; i++) begin
            req_data[i*DW +: DW] = 8'($urandom);
            req_dest[i*SW +: SW] = 3'($urandom);
        end
        req_valid = '1;
        for (int c = 0; c < 10; c++) begin
            #1;
            for (int i = 0; i < NR; i++) if (req_ready[i]) seen.push_back(i);
            step(gr);
        end
        req_valid = '0;
        chk("t2_grants", 32'(seen.size()), 5);
        for (int i = 0; i < 5 && i < seen.size(); i++) chk("t2_order", 32'(seen[i]), 32'(i % NR));
        step(gr);

        // Destination 3 not ready for 6 cycles
        req_valid            = 4'b0010;
        req_dest[1*SW +: SW] = 3'd3;
        req_data[1*DW +: DW] = 8'h3C;
        dest_ready           = 8'b1111_0111;
        step(gr);
        req_valid = '0;
        bcnt = 0;
        for (int k = 0; k < 7; k++) begin
            if (k == 6) dest_ready = '1;
            #1;
            if (busy) bcnt++;
            chk("t3_we", 32'(dmx_we), (k == 6) ? 32'h08 : 32'h0);
            step(gr);
        end
        chk("t3_busy_cycles", 32'(bcnt), 7);
        chk("t3_done", 32'(busy), 0);

        // Reset while waiting in ISSUE
        req_valid            = 4'b0001;
        req_dest[0*SW +: SW] = 3'd2;
        dest_ready           = '0;
        step(gr);
        req_valid = '0;
        step(gr);
        #1;
        reset = 1'b1;
        #1;
        chk("t4_busy", 32'(busy), 0);
        chk("t4_we", 32'(dmx_we), 0);
        chk("t4_data", 32'(dmx_data), 0);
        chk("t4_sel", 32'(dmx_select), 0);
        chk("t4_ready", 32'(req_ready), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset      = 1'b0;
        dest_ready = '1;
        repeat (4) step(gr);

`ifdef DEMUX_ARB_WAIT_TIMEOUT_EN
        // Timeout drop after 16 ISSUE cycles
        do_reset();
        req_valid            = 4'b0001;
        req_dest[0*SW +: SW] = 3'd6;
        dest_ready           = '0;
        step(gr);
        req_valid = '0;
        for (int k = 1; k <= 16; k++) begin
            #1;
            chk("t5_drop", 32'(drop_err), (k == 16) ? 1 : 0);
            chk("t5_we", 32'(dmx_we), 0);
            step(gr);
        end
        chk("t5_idle", 32'(busy), 0);

        // Ready arriving on the final cycle wins over the drop
        req_valid = 4'b0001;
        step(gr);
        req_valid = '0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 16) dest_ready[6] = 1'b1;
            #1;
            chk("t6_drop", 32'(drop_err), 0);
            chk("t6_we", 32'(dmx_we), (k == 16) ? 32'h40 : 32'h0);
            step(gr);
        end
        chk("t6_idle", 32'(busy), 0);
        dest_ready = '1;
`endif

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i]         = 1'b1;
                    req_data[i*DW +: DW] = 8'($urandom);
                    req_dest[i*SW +: SW] = 3'($urandom);
                end
            end
            dest_ready = 8'($urandom) | 8'($urandom);
            step(gr);
            if (gr >= 0) req_valid[gr] = 1'b0;
        end
        req_valid  = '0;
        dest_ready = '1;
        repeat (4) step(gr);
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
